// File: rtl/fir_output_reader.sv
// FIR output consumer: decimate, round, saturate, then buffer in a
// first-word-fall-through FIFO that drains over valid/ready.
module fir_output_reader #(
  parameter int IN_W  = 32,
  parameter int OUT_W = 16,
  parameter int SHIFT = 15,
  parameter int DECIM = 1,
  parameter int DEPTH = 4
) (
  input  logic                     CLK,
  input  logic                     rst,
  input  logic [IN_W-1:0]          in_data,
  input  logic                     in_valid,
  output logic [OUT_W-1:0]         out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int DW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int RS = (SHIFT > 0) ? SHIFT - 1 : 0;

  localparam logic [DW-1:0] DLAST = DW'(DECIM - 1);
  localparam logic [CW-1:0] FULLC = CW'(DEPTH);

  localparam logic signed [IN_W:0] RND =
    (SHIFT == 0) ? '0 : ((IN_W+1)'(1) << RS);
  localparam logic signed [IN_W:0] MAXV =
    {{(IN_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [IN_W:0] MINV = ~MAXV;

  logic [DW-1:0]          dcnt;
  logic                   accept;
  logic signed [IN_W:0]   ext;
  logic signed [IN_W:0]   rnd_sum;
  logic signed [IN_W:0]   shifted;
  logic [OUT_W-1:0]       scaled;
  logic                   stage_valid;
  logic [OUT_W-1:0]       stage_data;
  logic [OUT_W-1:0]       mem [DEPTH];
  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          rd_ptr;
  logic                   full;
  logic                   push;
  logic                   pop;
  logic                   drop;

  assign accept = in_valid && (dcnt == '0);

  // Round half toward +inf, shift, then clamp into the output range.
  always_comb begin
    ext     = $signed({in_data[IN_W-1], in_data});
    rnd_sum = ext + RND;
    shifted = rnd_sum >>> SHIFT;
    scaled  = shifted[OUT_W-1:0];
    if (shifted > MAXV) begin
      scaled = MAXV[OUT_W-1:0];
    end else if (shifted < MINV) begin
      scaled = MINV[OUT_W-1:0];
    end
  end

  // Decimation phase counter, advanced by every valid input.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      dcnt <= '0;
    end else if (in_valid) begin
      dcnt <= (dcnt == DLAST) ? '0 : dcnt + 1'b1;
    end
  end

  // Stage register holding the scaled accepted sample.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      stage_valid <= 1'b0;
      stage_data  <= '0;
    end else begin
      stage_valid <= accept;
      if (accept) begin
        stage_data <= scaled;
      end
    end
  end

  assign full      = (count == FULLC);
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  assign push      = stage_valid && (!full || pop);
  assign drop      = stage_valid && full && !pop;
  assign out_data  = mem[rd_ptr];

  // FIFO storage and write pointer.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
    end else if (push) begin
      mem[wr_ptr] <= stage_data;
      wr_ptr      <= wr_ptr + 1'b1;
    end
  end

  // Read pointer, occupancy and sticky drop flag.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fir_output_reader.sv
// Bench for fir_output_reader: two instances (DECIM=1 and DECIM=3)
// share stimulus and are compared against a queue-based model.
module tb_fir_output_reader;

  localparam int IN_W  = 32;
  localparam int OUT_W = 16;
  localparam int SHIFT = 15;
  localparam int DEPTH = 4;

  logic              CLK = 1'b0;
  logic              rst;
  logic [IN_W-1:0]   in_data;
  logic              in_valid;
  logic              out_ready;

  logic [OUT_W-1:0]  a_data, b_data;
  logic              a_valid, b_valid;
  logic [2:0]        a_count, b_count;
  logic              a_ovf, b_ovf;

  int n_assert = 0;
  int n_fail   = 0;

  int  qa[$];
  int  qb[$];
  bit  sva, svb;
  int  sda, sdb;
  bit  ova, ovb;
  int  nva, nvb;

  fir_output_reader #(
    .IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT), .DECIM(1), .DEPTH(DEPTH)
  ) dut_a (
    .CLK(CLK), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .out_data(a_data), .out_valid(a_valid), .out_ready(out_ready),
    .count(a_count), .overflow(a_ovf)
  );

  fir_output_reader #(
    .IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT), .DECIM(3), .DEPTH(DEPTH)
  ) dut_b (
    .CLK(CLK), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .out_data(b_data), .out_valid(b_valid), .out_ready(out_ready),
    .count(b_count), .overflow(b_ovf)
  );

  always #5 CLK = ~CLK;

  function automatic int scale(logic [IN_W-1:0] d);
    longint t;
    t = longint'($signed(d)) + (longint'(1) << (SHIFT - 1));
    t = t >>> SHIFT;
    if (t > 32767) t = 32767;
    if (t < -32768) t = -32768;
    return int'(t);
  endfunction

  task automatic check(string tag, longint obs, longint exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_step(inout int q[$], inout bit sv, inout int sd,
                            inout bit ov, inout int nv, input int decim);
    bit pop;
    pop = (q.size() != 0) && out_ready;
    if (sv) begin
      if (q.size() < DEPTH || pop) begin
        if (pop) void'(q.pop_front());
        q.push_back(sd);
      end else begin
        ov = 1'b1;
      end
    end else if (pop) begin
      void'(q.pop_front());
    end
    sv = in_valid && (nv % decim == 0);
    if (sv) sd = scale(in_data);
    if (in_valid) nv++;
  endtask

  task automatic model_reset();
    qa.delete(); qb.delete();
    sva = 0; svb = 0; sda = 0; sdb = 0;
    ova = 0; ovb = 0; nva = 0; nvb = 0;
  endtask

  task automatic check_all();
    check("a_valid", a_valid, qa.size() != 0);
    check("a_count", a_count, qa.size());
    check("a_ovf", a_ovf, ova);
    if (qa.size() != 0) check("a_data", $signed(a_data), qa[0]);
    check("b_valid", b_valid, qb.size() != 0);
    check("b_count", b_count, qb.size());
    check("b_ovf", b_ovf, ovb);
    if (qb.size() != 0) check("b_data", $signed(b_data), qb[0]);
  endtask

  task automatic cycle();
    @(posedge CLK);
    model_step(qa, sva, sda, ova, nva, 1);
    model_step(qb, svb, sdb, ovb, nvb, 3);
    #1;
    check_all();
  endtask

  task automatic send(logic [IN_W-1:0] d, bit v, bit r);
    in_data  = d;
    in_valid = v;
    out_ready = r;
    cycle();
  endtask

  task automatic check_reset_state(string tag);
    check({tag, "_a_valid"}, a_valid, 0);
    check({tag, "_a_count"}, a_count, 0);
    check({tag, "_a_ovf"}, a_ovf, 0);
    check({tag, "_a_data"}, a_data, 0);
    check({tag, "_b_valid"}, b_valid, 0);
    check({tag, "_b_count"}, b_count, 0);
    check({tag, "_b_ovf"}, b_ovf, 0);
    check({tag, "_b_data"}, b_data, 0);
  endtask

  // Asynchronous pulse between edges; inputs idle, effect checked at once.
  task automatic async_reset(string tag);
    in_valid = 0;
    #2 rst = 1;
    #1 check_reset_state(tag);
    model_reset();
    #1 rst = 0;
  endtask

  function automatic logic [IN_W-1:0] sv_of(int n);
    return IN_W'(n) << SHIFT;
  endfunction

  initial begin
    rst = 1; in_data = '0; in_valid = 0; out_ready = 0;
    model_reset();
    #3 check_reset_state("por");
    @(negedge CLK);
    rst = 0;

    // Rounding
    send(32'h0000_4000, 1, 1);
    send(32'hFFFF_C000, 1, 1);
    check("t1_first", $signed(a_data), 1);
    send(32'h0000_3FFF, 1, 1);
    repeat (3) send('0, 0, 1);

    // Saturation
    send(32'h7FFF_FFFF, 1, 1);
    send(32'h8000_0000, 1, 1);
    check("t2_max", a_data, 16'h7FFF);
    send('0, 0, 1);
    check("t2_min", a_data, 16'h8000);
    repeat (2) send('0, 0, 1);

    // Full and overflow
    for (int n = 1; n <= 6; n++) send(sv_of(n), 1, 0);
    check("t3_ovf", a_ovf, 1);
    check("t3_cnt", a_count, 4);
    send('0, 0, 0);
    repeat (6) send('0, 0, 1);

    // Push and pop while full
    async_reset("t4r");
    for (int n = 1; n <= 4; n++) send(sv_of(n), 1, 0);
    send(sv_of(5), 1, 0);
    send('0, 0, 1);
    check("t4_cnt", a_count, 4);
    check("t4_ovf", a_ovf, 0);
    repeat (6) send('0, 0, 1);

    // Decimation
    async_reset("t5r");
    for (int n = 1; n <= 9; n++) send(sv_of(n), 1, 1);
    repeat (3) send('0, 0, 1);
    for (int n = 10; n <= 21; n++) begin
      send(sv_of(n), 1, 1);
      if (n % 2 == 0) send('0, 0, 1);
    end
    repeat (4) send('0, 0, 1);

    // Reset mid-operation
    async_reset("t6a");
    for (int n = 1; n <= 5; n++) send(sv_of(n), 1, 0);
    send('0, 0, 0);
    send('0, 0, 1);
    check("t6_pre_cnt", a_count, 3);
    check("t6_pre_ovf", a_ovf, 1);
    async_reset("t6r");
    send(sv_of(9), 1, 1);
    send('0, 0, 0);
    check("t6_nine", $signed(a_data), 9);
    send('0, 0, 1);
    repeat (2) send('0, 0, 1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [IN_W-1:0] d;
      case ($urandom_range(0, 3))
        0: d = $urandom;
        1: d = IN_W'($signed($urandom_range(0, 65535) - 32768)) << SHIFT;
        2: d = IN_W'($urandom_range(0, 1 << 16)) - 32'h0000_8000;
        default: d = ($urandom_range(0, 1)) ? 32'h7FFF_FFFF : 32'h8000_0000;
      endcase
      send(d, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
      if (i == 200) async_reset("rnd_r");
    end
    repeat (8) send('0, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/fir_output_reader.md
# fir_output_reader

Consumer end of the FIR filter datapath. It accepts full-width accumulator samples from the filter output, decimates, rounds and saturates them to output width, and buffers them in a small first-word-fall-through FIFO. The FIFO drains to a downstream sink over a valid/ready handshake. The block sits between the last FIR adder stage and any slower downstream consumer, and absorbs sink back-pressure.

## Interface
- IN_W, 32, width of the signed filter accumulator sample
- OUT_W, 16, width of the signed output sample
- SHIFT, 15, arithmetic right-shift applied when scaling, 0..IN_W-1
- DECIM, 1, decimation factor, >= 1
- DEPTH, 4, FIFO entries, power of two, >= 2
- CLK  input  1  sole clock; all state updates on rising edge
- rst  input  1  reset, asynchronous, active-high
- in_data  input  IN_W  signed filter output sample
- in_valid  input  1  in_data is valid this cycle; there is no back-pressure to the filter
- out_data  output  OUT_W  signed scaled sample at the FIFO head
- out_valid  output  1  FIFO non-empty
- out_ready  input  1  sink accepts out_data this cycle
- count  output  $clog2(DEPTH)+1  current FIFO occupancy
- overflow  output  1  sticky flag: a sample was dropped because the FIFO was full

## Operation
- **Decimation**
  - Counter dcnt runs 0..DECIM-1 and advances on every in_valid, wrapping to 0.
  - A sample is accepted only when in_valid=1 and dcnt=0; all others are discarded.
  - With DECIM=1, every valid sample is accepted.
- **Scaling (stage register)**
  - Compute in IN_W+1 bits: t = in_data + 2^(SHIFT-1), or t = in_data when SHIFT=0. Then t >>>= SHIFT (round half toward +inf).
  - Saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - The result and a stage-valid bit are registered on the accept cycle.
- **FIFO**
  - DEPTH entries with read and write pointers that wrap modulo DEPTH. Occupancy is held in count.
  - push = stage_valid and (count<DEPTH or pop).
  - pop = out_valid and out_ready.
  - Simultaneous push and pop leaves count unchanged. This includes when the FIFO is full: the popped entry frees the slot.
  - If stage_valid=1 while full and no pop, the sample is dropped, overflow sets to 1, and FIFO contents are unchanged.
  - out_valid = (count != 0). out_data = mem[rd_ptr], combinational from the registered memory/pointer.
  - out_ready with an empty FIFO has no effect.
  - out_data is held stable while out_valid=1 and out_ready=0.
- **Reset**
  - Asynchronous assertion clears dcnt, stage_valid, pointers, count and overflow, so out_valid=0, count=0, overflow=0, and out_data reads 0.
  - Memory contents are cleared to 0.
  - In-flight stage samples are lost.
  - overflow clears only on reset.

## Timing
- Accepted sample at edge k lands in the stage register at edge k. It is pushed at edge k+1 and is visible on out_data/out_valid after edge k+1 if the FIFO was empty. Latency is 2 cycles from in_valid to out_valid.
- Sustained throughput is one sample per cycle when out_ready stays high.
- count and overflow update on the same edge as the corresponding push, pop or drop.
- Reset deassertion: the first in_valid sampled at the next rising edge is treated as dcnt=0 (accepted).

## Test plan
1. **Rounding.** Defaults, in_valid one cycle each with in_data = 0x00004000, 0xFFFFC000, 0x00003FFF, out_ready=1 → out_data = 1, 0, 0, each 2 cycles after its input. count never exceeds 1.
2. **Saturation.** in_data = 0x7FFFFFFF then 0x80000000 → out_data = 0x7FFF then 0x8000. overflow stays 0.
3. **Full and overflow.** out_ready=0, push 6 consecutive samples scaled 1..6 → count reaches 4, overflow=1 two cycles after the 5th input. Raising out_ready then yields 1,2,3,4 on consecutive cycles, then out_valid=0.
4. **Push and pop while full.** FIFO holds 1..4, out_ready=1, and a new sample 5 arrives at the stage the same cycle → count stays 4, overflow stays 0. Output sequence is 1,2,3,4,5.
5. **Decimation.** DECIM=3, in_valid continuous with scaled values 1..9 → output 1, 4, 7 only. With in_valid gaps inserted, selection is still every third valid sample.
6. **Reset mid-operation.** FIFO holding 3 entries, overflow=1, assert rst asynchronously between edges → out_valid=0, count=0, overflow=0 immediately. After release, a new sample 9 appears after 2 cycles as the only output.
